// File: rtl/dmem_block_ctrl.sv
// Block-organised data memory behind the data cache.
// Serves one block read or write at a time with a fixed, counted latency.
module dmem_block_ctrl #(
  parameter int ADDR_W  = 6,
  parameter int BLOCK_W = 32,
  parameter int LATENCY = 5
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               read,
  input  logic               write,
  input  logic [ADDR_W-1:0]  address,
  input  logic [BLOCK_W-1:0] writedata,
  output logic [BLOCK_W-1:0] readdata,
  output logic               busywait,
  output logic               protocol_err
);

  localparam int DEPTH = 1 << ADDR_W;

  typedef enum logic [1:0] {
    S_IDLE,
    S_BUSY,
    S_DONE
  } state_e;

  state_e               state_q, state_d;
  logic [7:0]           cnt_q, cnt_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [BLOCK_W-1:0]   wdata_q, wdata_d;
  logic [BLOCK_W-1:0]   rdata_q, rdata_d;
  logic                 wr_q, wr_d;
  logic                 perr_q, perr_d;
  logic                 mem_we;
  logic [BLOCK_W-1:0]   mem_q [DEPTH];

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    wr_d    = wr_q;
    perr_d  = 1'b0;
    mem_we  = 1'b0;
    unique case (state_q)
      S_IDLE: begin
        if (read || write) begin
          addr_d  = address;
          wdata_d = writedata;
          // A simultaneous read+write is served as a read only
          wr_d    = write & ~read;
          perr_d  = read & write;
          cnt_d   = 8'(LATENCY - 1);
          state_d = S_BUSY;
        end
      end
      S_BUSY: begin
        cnt_d = cnt_q - 8'd1;
        if (cnt_q == 8'd0) begin
          cnt_d   = 8'd0;
          state_d = S_DONE;
          if (wr_q) mem_we = 1'b1;
          else      rdata_d = mem_q[addr_q];
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
      wr_q    <= 1'b0;
      perr_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
      wr_q    <= wr_d;
      perr_q  <= perr_d;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (mem_we) begin
      mem_q[addr_q] <= wdata_q;
    end
  end

  // IDLE answers a new request combinationally so the cache stalls at once
  assign busywait = (state_q == S_BUSY) ||
                    ((state_q == S_IDLE) && (read || write));

  assign readdata     = rdata_q;
  assign protocol_err = perr_q;

endmodule

// File: tb/tb_dmem_block_ctrl.sv
// Randomised scoreboard bench for dmem_block_ctrl.
// A driver issues requests; a negedge monitor checks each completion.
module tb_dmem_block_ctrl;

  localparam int LAT = 5;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        read = 1'b0;
  logic        write = 1'b0;
  logic [5:0]  address = '0;
  logic [31:0] writedata = '0;
  logic [31:0] readdata;
  logic        busywait;
  logic        protocol_err;

  dmem_block_ctrl #(
    .ADDR_W (6),
    .BLOCK_W(32),
    .LATENCY(LAT)
  ) dut (
    .clock       (clock),
    .reset       (reset),
    .read        (read),
    .write       (write),
    .address     (address),
    .writedata   (writedata),
    .readdata    (readdata),
    .busywait    (busywait),
    .protocol_err(protocol_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    bit          both;
    logic [31:0] rdata;
  } exp_t;

  exp_t        sb[$];
  logic [31:0] mem_m [64];
  logic [31:0] rdata_m;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          bw_cnt = 0;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int i = 0; i < 64; i++) mem_m[i] = '0;
    rdata_m = '0;
  endtask

  // Completion monitor: busywait falling marks DONE
  always @(negedge clock) begin
    exp_t e;
    bit   exp_perr;
    if (!reset) begin
      bw_cnt = 0;
    end else begin
      exp_perr = busywait && bw_cnt == 1 && sb.size() > 0 && sb[0].both;
      chk("protocol_err", {31'd0, protocol_err}, {31'd0, exp_perr});
      if (busywait) begin
        bw_cnt++;
      end else if (bw_cnt > 0) begin
        if (sb.size() == 0) begin
          chk("unexpected_done", 32'd1, 32'd0);
        end else begin
          e = sb.pop_front();
          chk("readdata", readdata, e.rdata);
          chk("busy_len", bw_cnt, LAT + 1);
        end
        bw_cnt = 0;
      end
    end
  end

  task automatic do_op(input bit rd, input bit wr, input logic [5:0] a,
                       input logic [31:0] wd, input bit scramble);
    exp_t e;
    int   n;
    @(posedge clock); #1;
    if (rd)      rdata_m = mem_m[a];
    else if (wr) mem_m[a] = wd;
    e.both  = rd && wr;
    e.rdata = rdata_m;
    sb.push_back(e);
    read = rd; write = wr; address = a; writedata = wd;
    @(posedge clock); #1;
    if (scramble) begin
      address   = 6'($urandom);
      writedata = $urandom;
      if ($urandom_range(0, 1) == 1) begin
        read = 1'b0; write = 1'b0;
      end
    end
    n = 0;
    do begin
      @(negedge clock);
      n++;
    end while (busywait && n < LAT + 10);
    if (busywait) chk("busy_timeout", 32'd1, 32'd0);
    @(posedge clock); #1;
    read = 1'b0; write = 1'b0;
    @(negedge clock);
    chk("idle_after_done", {31'd0, busywait}, 32'd0);
  endtask

  initial begin
    logic [5:0]  a;
    logic [31:0] wd;
    int          r;
    model_clear();
    #3;
    chk("rst_busywait", {31'd0, busywait}, 32'd0);
    chk("rst_readdata", readdata, 32'd0);
    chk("rst_perr", {31'd0, protocol_err}, 32'd0);
    @(negedge clock);
    reset = 1'b1;

    do_op(1, 0, 6'h00, 32'h0, 0);
    do_op(0, 1, 6'h15, 32'hDEADBEEF, 0);
    do_op(1, 0, 6'h15, 32'h0, 0);

    do_op(0, 1, 6'h3F, 32'hA5A5A5A5, 0);
    @(posedge clock); #1;
    write = 1'b1; address = 6'h01; writedata = 32'h0;
    sb.push_back('{both: 1'b0, rdata: rdata_m});
    address = 6'h3F; writedata = 32'hA5A5A5A5;
    mem_m[6'h3F] = 32'hA5A5A5A5;
    @(posedge clock); #1;
    address = 6'h01; writedata = 32'h0;
    do begin @(negedge clock); end while (busywait);
    @(posedge clock); #1;
    write = 1'b0;
    do_op(1, 0, 6'h3F, 32'h0, 0);
    do_op(1, 0, 6'h01, 32'h0, 0);

    do_op(0, 1, 6'h21, 32'h5555AAAA, 0);
    @(posedge clock); #1;
    write = 1'b1; address = 6'h07; writedata = 32'h12345678;
    repeat (3) @(posedge clock);
    #2;
    reset = 1'b0;
    write = 1'b0;
    #1;
    chk("abort_busywait", {31'd0, busywait}, 32'd0);
    chk("abort_readdata", readdata, 32'd0);
    model_clear();
    #20;
    @(negedge clock);
    reset = 1'b1;
    do_op(1, 0, 6'h07, 32'h0, 0);
    do_op(1, 0, 6'h21, 32'h0, 0);

    do_op(0, 1, 6'h02, 32'hCAFEF00D, 0);
    do_op(1, 1, 6'h02, 32'h11111111, 0);
    do_op(1, 0, 6'h02, 32'h0, 0);

    do_op(0, 1, 6'h0A, 32'hB16B00B5, 0);
    do_op(0, 1, 6'h1A, 32'h0BADCAFE, 0);
    do_op(0, 1, 6'h0A, 32'hFEEDFACE, 0);
    do_op(1, 0, 6'h1A, 32'h0, 0);
    do_op(1, 0, 6'h0A, 32'h0, 0);

    for (int i = 0; i < 120; i++) begin
      r  = $urandom_range(0, 9);
      a  = ($urandom_range(0, 1) == 1) ? 6'($urandom_range(0, 7))
                                       : 6'($urandom);
      wd = $urandom;
      do_op(r < 4 || r == 9, r >= 4, a, wd, $urandom_range(0, 3) == 0);
    end

    repeat (4) @(negedge clock);
    chk("sb_empty", sb.size(), 32'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/dmem_block_ctrl.md
Name: dmem_block_ctrl

Overview:
Block-organised data memory that sits directly downstream of the data cache and services its miss-fill reads and dirty-block write-backs. It stores 64 blocks of 32 bits (256 bytes) and models main-memory latency with a cycle counter and FSM. It uses a busywait handshake, so the cache controller can stall on it cycle-accurately.

Parameters:
ADDR_W, 6, block address width (64 blocks)
BLOCK_W, 32, block width in bits (4 bytes, little-endian lanes: byte {address,2'b00} in [7:0])
LATENCY, 5, cycles from request capture to data-ready; legal range 1..255

Ports:
clock  input  1  system clock, all state on rising edge
reset  input  1  asynchronous, active-low reset
read  input  1  block read request (held by requester until busywait falls)
write  input  1  block write request (held by requester until busywait falls)
address  input  ADDR_W  block address
writedata  input  BLOCK_W  block to be written
readdata  output  BLOCK_W  block returned by last completed read
busywait  output  1  high while a request is pending or in progress
protocol_err  output  1  one-cycle pulse when read and write are both sampled high

Behaviour:
- Reset (reset low, asynchronous): state=IDLE, counter=0, busywait=0, readdata=0, protocol_err=0, all 64 blocks cleared to 0. An in-flight operation is aborted and a pending write is not committed. On reset release, the block waits for the next rising edge.
- States: IDLE, BUSY, DONE.
- IDLE: busywait is combinational, high whenever read or write is high, so the requester sees busywait=1 at the first edge after raising its request.
  - Rising edge with read or write high: capture address, writedata and op; counter=LATENCY-1; go to BUSY.
  - read and write both high: perform a read and ignore the write; protocol_err pulses high for the next cycle.
- BUSY: busywait=1 registered.
  - Each edge: counter decrements.
  - Edge with counter==0: go to DONE. A read loads readdata from mem[captured address]; a write commits captured writedata to mem[captured address].
  - Changes to read, write, address or writedata during BUSY are ignored. Deasserting the request does not abort the operation.
- DONE: busywait=0 for exactly one cycle; readdata is stable.
  - Next edge: go to IDLE unconditionally. A request still high at that edge is not re-accepted, because the requester drops it on the same edge.
- Timing: request sampled at edge T0 → DONE entered at edge T0+LATENCY → requester samples busywait=0 and readdata at edge T0+LATENCY+1.
- readdata holds its value across writes and idle cycles; only a completed read updates it.
- Write followed by read of the same block returns the new data, with no forwarding required because operations are serialised.
- address is used unsigned; all 64 blocks are reachable, with no wrap or out-of-range case.
- Back-to-back requests: minimum spacing is one IDLE edge after DONE.
- counter width is 8 bits. LATENCY=1 gives BUSY for exactly one edge.

Test Plan:
- Reset while idle, then read block 0x00 → readdata=0x00000000; busywait high for 6 edges (LATENCY=5), then low for 1 cycle.
- Write block 0x15 with 0xDEADBEEF, then read 0x15 → readdata=0xDEADBEEF at edge T0+6 of the read; busywait low exactly one cycle per operation.
- Write 0x3F=0xA5A5A5A5; during BUSY, change address to 0x01 and writedata to 0x0 → mem[0x3F]=0xA5A5A5A5 and mem[0x01]=0 on read-back.
- Assert reset mid-BUSY of a write to 0x07=0x12345678 → busywait=0 immediately; read 0x07 after release returns 0x00000000.
- read and write both high at address 0x02, after mem[0x02]=0xCAFEF00D → protocol_err pulses one cycle; mem unchanged; readdata=0xCAFEF00D.
- Drive it with the data cache: dirty miss on tag/index 0x1A → write-back to the old block, then fill from 0x1A; the cache ends with correct data and no extra memory request issued at the DONE→IDLE edge.
